// File: rtl/ppu_pixel_stream_pkg.sv
// ppu_pixel_stream_pkg: shared video types and default picture geometry.
package ppu_pixel_stream_pkg;
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } state_e;
  localparam int DEF_IMAGE_W = 256;
  localparam int DEF_IMAGE_H = 240;
endpackage

// File: rtl/ppu_pixel_stream_pixel_counter.sv
// pixel_counter: x/y raster position and per-frame accepted pixel count.
module pixel_counter #(
  parameter int IMAGE_W = 256,
  parameter int IMAGE_H = 240,
  localparam int XW = IMAGE_W > 1 ? $clog2(IMAGE_W) : 1,
  localparam int YW = IMAGE_H > 1 ? $clog2(IMAGE_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_last,
  output logic          frame_full
);
  localparam int CW = $clog2(IMAGE_W * IMAGE_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);
  localparam logic [CW-1:0] TOTAL  = CW'(IMAGE_W * IMAGE_H);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] count_q, count_d;
  assign line_last  = x_q == X_LAST;
  assign frame_full = count_q == TOTAL;
  assign x = x_q;
  assign y = y_q;
  always_comb begin
    x_d     = clear ? '0 : advance ? (line_last ? '0 : x_q + 1'b1) : x_q;
    y_d     = clear ? '0 : (advance && line_last) ? (y_q == Y_LAST ? '0 : y_q + 1'b1) : y_q;
    count_d = clear ? '0 : advance ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/ppu_pixel_stream.sv
// ppu_pixel_stream: turns PPU dots plus vblank into a framed pixel stream
// with line/frame markers and a frame-size error pulse.
module ppu_pixel_stream
  import ppu_pixel_stream_pkg::*;
#(
  parameter int IMAGE_W = DEF_IMAGE_W,
  parameter int IMAGE_H = DEF_IMAGE_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ppu_px_valid,
  input  logic [5:0] ppu_px,
  input  logic       ppu_vblank,
  output logic [7:0] pixel,
  output logic       pixel_en,
  output logic       frame,
  output logic       line_end,
  output logic       frame_err
);
  localparam int XW = IMAGE_W > 1 ? $clog2(IMAGE_W) : 1;
  localparam int YW = IMAGE_H > 1 ? $clog2(IMAGE_H) : 1;
  state_e state_q, state_d;
  logic vblank_q, armed_q, ovf_q, ovf_d;
  logic [7:0] pixel_q, pixel_d;
  logic pixel_en_q, pixel_en_d, frame_q, frame_d;
  logic line_end_q, line_end_d, frame_err_q, frame_err_d;
  logic rise, fall, accept, clear, line_last, frame_full;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic unused_xy;
  // armed_q masks the first post-reset cycle, whose vblank_q is not a real sample
  assign rise = armed_q & ppu_vblank & ~vblank_q;
  assign fall = armed_q & ~ppu_vblank & vblank_q;
  assign unused_xy = ^{x, y};
  pixel_counter #(.IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H)) u_pixel_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .advance   (accept),
    .x         (x),
    .y         (y),
    .line_last (line_last),
    .frame_full(frame_full)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_SYNC;
      vblank_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vblank_q <= ppu_vblank;
      armed_q  <= 1'b1;
    end
  end
  always_comb begin
    state_d = (rise && state_q != VBLANK) ? VBLANK :
              (fall && state_q == VBLANK) ? ACTIVE : state_q;
  end
  // a vblank rise wins over a coincident dot
  always_comb begin
    accept      = state_q == ACTIVE && ppu_px_valid && !rise && !frame_full;
    clear       = state_q == VBLANK && fall;
    pixel_d     = accept ? {2'b00, ppu_px} : pixel_q;
    pixel_en_d  = accept;
    line_end_d  = accept && line_last;
    frame_d     = rise && state_q != VBLANK;
    frame_err_d = rise && state_q == ACTIVE && (!frame_full || ovf_q);
    ovf_d       = clear ? 1'b0 :
                  (state_q == ACTIVE && ppu_px_valid && !rise && frame_full) ? 1'b1 : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q     <= '0;
      pixel_en_q  <= 1'b0;
      frame_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pixel_q     <= pixel_d;
      pixel_en_q  <= pixel_en_d;
      frame_q     <= frame_d;
      line_end_q  <= line_end_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end
  assign pixel     = pixel_q;
  assign pixel_en  = pixel_en_q;
  assign frame     = frame_q;
  assign line_end  = line_end_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ppu_pixel_stream.sv
// tb_ppu_pixel_stream: table vectors, directed frame scenarios and a random
// soak, all checked against a frame-level reference model.
module tb_ppu_pixel_stream;
  localparam int W = 16;
  localparam int H = 8;
  localparam int TOTAL = W * H;
  logic clk = 1'b0, rst_n = 1'b0, v = 1'b0, vb = 1'b0;
  logic [5:0] px = '0;
  logic [7:0] pixel;
  logic pixel_en, frame, line_end, frame_err;
  int checks = 0, errors = 0;
  int m_mode, m_cnt;
  bit m_armed, m_prev, m_ovf;
  bit e_en, e_fr, e_le, e_err;
  logic [7:0] e_pix;
  int n_en, n_fr, n_le, n_err, idx;
  typedef struct {
    logic r, v;
    logic [5:0] p;
    logic b, en, fr, le, err;
    logic [7:0] pix;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  ppu_pixel_stream #(.IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .ppu_px_valid(v), .ppu_px(px), .ppu_vblank(vb),
    .pixel(pixel), .pixel_en(pixel_en), .frame(frame), .line_end(line_end), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model modes: 0 waiting for sync, 1 in vblank, 2 active picture
  task automatic cyc(input logic r, input logic vv, input logic [5:0] p, input logic b);
    bit rise, fall;
    @(negedge clk);
    rst_n = r; v = vv; px = p; vb = b;
    if (!r) begin
      {e_en, e_fr, e_le, e_err} = '0;
      m_mode = 0; m_armed = 0; m_prev = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      rise  = m_armed && b && !m_prev;
      fall  = m_armed && !b && m_prev;
      e_fr  = rise && m_mode != 1;
      e_err = rise && m_mode == 2 && (m_cnt != TOTAL || m_ovf);
      e_en  = m_mode == 2 && vv && !rise && m_cnt < TOTAL;
      e_pix = {2'b00, p};
      e_le  = e_en && (m_cnt % W == W - 1);
      if (m_mode == 2 && vv && !rise && m_cnt >= TOTAL) m_ovf = 1;
      if (e_en) m_cnt++;
      if (rise && m_mode != 1) m_mode = 1;
      else if (fall && m_mode == 1) begin m_mode = 2; m_cnt = 0; m_ovf = 0; end
      m_prev = b; m_armed = 1;
    end
    @(posedge clk);
    #1;
    chk("pixel_en", pixel_en, e_en);
    chk("frame", frame, e_fr);
    chk("line_end", line_end, e_le);
    chk("frame_err", frame_err, e_err);
    if (e_en) chk("pixel", pixel, e_pix);
    n_en += pixel_en; n_fr += frame; n_le += line_end; n_err += frame_err;
  endtask

  task automatic tally_clr();
    n_en = 0; n_fr = 0; n_le = 0; n_err = 0;
  endtask

  task automatic send(input int n);
    int sent = 0;
    bit vv;
    while (sent < n) begin
      vv = $urandom_range(0, 3) != 0;
      cyc(1, vv, 6'(idx % 64), 0);
      if (vv) begin idx++; sent++; end
    end
  endtask

  task automatic vbl(input int n);
    repeat (n) cyc(1, 0, 0, 1);
  endtask

  task automatic frame_run(input int n);
    cyc(1, 0, 0, 0);
    idx = 0;
    send(n);
    vbl(3);
  endtask

  initial begin
    bit sb, sr;
    tbl[0]  = '{0, 0, 0,  0, 0, 0, 0, 0, 8'd0};
    tbl[1]  = '{1, 1, 5,  0, 0, 0, 0, 0, 8'd0};
    tbl[2]  = '{1, 1, 6,  1, 0, 1, 0, 0, 8'd0};
    tbl[3]  = '{1, 1, 7,  1, 0, 0, 0, 0, 8'd0};
    tbl[4]  = '{1, 1, 8,  0, 0, 0, 0, 0, 8'd0};
    tbl[5]  = '{1, 1, 9,  0, 1, 0, 0, 0, 8'd9};
    tbl[6]  = '{1, 0, 10, 0, 0, 0, 0, 0, 8'd0};
    tbl[7]  = '{1, 1, 11, 1, 0, 1, 0, 1, 8'd0};
    tbl[8]  = '{1, 0, 0,  1, 0, 0, 0, 0, 8'd0};
    tbl[9]  = '{0, 0, 0,  1, 0, 0, 0, 0, 8'd0};
    tbl[10] = '{1, 0, 0,  1, 0, 0, 0, 0, 8'd0};
    tbl[11] = '{1, 0, 0,  0, 0, 0, 0, 0, 8'd0};
    tbl[12] = '{1, 1, 3,  0, 0, 0, 0, 0, 8'd0};
    tbl[13] = '{1, 0, 0,  1, 0, 1, 0, 0, 8'd0};
    tally_clr();
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].b);
      chk("tbl_pixel_en", pixel_en, tbl[i].en);
      chk("tbl_frame", frame, tbl[i].fr);
      chk("tbl_line_end", line_end, tbl[i].le);
      chk("tbl_frame_err", frame_err, tbl[i].err);
      if (tbl[i].en || !tbl[i].r) chk("tbl_pixel", pixel, tbl[i].pix);
    end
    // unsynced: vblank only falls, so a whole frame of dots is ignored
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    tally_clr();
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    idx = 0; send(TOTAL);
    chk("wait_sync_no_en", n_en, 0);
    chk("wait_sync_no_frame", n_fr, 0);
    vbl(3);
    chk("first_sync_frame", n_fr, 1);
    chk("first_sync_err", n_err, 0);
    // full frame
    tally_clr(); frame_run(TOTAL);
    chk("full_en", n_en, TOTAL);
    chk("full_line_end", n_le, H);
    chk("full_err", n_err, 0);
    chk("full_frame", n_fr, 1);
    // short frame, then a clean one counting from the origin
    tally_clr(); frame_run(TOTAL - 8);
    chk("short_en", n_en, TOTAL - 8);
    chk("short_err", n_err, 1);
    tally_clr(); frame_run(TOTAL);
    chk("after_short_line_end", n_le, H);
    chk("after_short_err", n_err, 0);
    // overflowing frame
    tally_clr(); frame_run(TOTAL + 10);
    chk("over_en", n_en, TOTAL);
    chk("over_err", n_err, 1);
    // dot coincident with vblank rise
    tally_clr();
    cyc(1, 0, 0, 0); idx = 0; send(5);
    cyc(1, 1, 6'd7, 1);
    chk("coincide_dropped", pixel_en, 0);
    chk("coincide_frame", frame, 1);
    vbl(2);
    chk("coincide_en", n_en, 5);
    // reset mid-frame, then resync
    cyc(1, 0, 0, 0); idx = 0; send(60);
    tally_clr();
    cyc(0, 0, 0, 1); cyc(0, 1, 1, 1); cyc(0, 1, 2, 0);
    cyc(1, 1, 3, 0); cyc(1, 1, 4, 0);
    chk("reset_no_frame", n_fr, 0);
    chk("reset_no_err", n_err, 0);
    chk("reset_no_en", n_en, 0);
    vbl(3);
    chk("resync_frame", n_fr, 1);
    tally_clr(); frame_run(TOTAL);
    chk("resync_full_en", n_en, TOTAL);
    chk("resync_full_err", n_err, 0);
    // random soak
    sb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) sb = ~sb;
      sr = $urandom_range(0, 499) != 0;
      cyc(sr, 1'($urandom), 6'($urandom), sb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
